// File: rtl/i2c_pkg.sv
// Shared widths and arbiter state encoding for the I2C transaction arbiter.
package i2c_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } arb_state_e;
endpackage

// File: rtl/i2c_sync_bit.sv
// Flop chain bringing one bit from the i2c_clk domain into clk.
// Resets to 1 so an idle master reads as ready.
module i2c_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '1;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master among NREQ requesters: grants,
// latches one transaction, handshakes enable/ready with the master and returns the result.
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int START_TO    = 64,
  parameter int DONE_TO     = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [ADDR_W*NREQ-1:0]   req_addr,
  input  logic [NREQ-1:0]          req_rw,
  input  logic [DATA_W*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [ADDR_W-1:0]        m_addr,
  output logic [DATA_W-1:0]        m_data_in,
  output logic                     m_rw,
  output logic                     m_enable,
  input  logic                     m_ready,
  input  logic [DATA_W-1:0]        m_data_out
);
  localparam int IDX_W  = $clog2(NREQ);
  localparam int TO_MAX = (START_TO > DONE_TO) ? START_TO : DONE_TO;
  localparam int CNT_W  = $clog2(TO_MAX + 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TO - 1);
  localparam logic [CNT_W-1:0] DONE_LAST  = CNT_W'(DONE_TO - 1);

  arb_state_e       state, next_state;
  logic             rdy_s;
  logic [IDX_W-1:0] ptr, owner, pick_idx;
  logic             pick_found, grant, err;
  logic [CNT_W-1:0] cnt;

  // First requesting index at or after ptr, wrapping; MSB of the result flags a hit.
  function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] req,
                                             input logic [IDX_W-1:0] start);
    logic [IDX_W:0] res;
    int idx;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  i2c_sync_bit #(.STAGES(SYNC_STAGES)) u_ready_sync (
    .clk   (clk),
    .reset (reset),
    .d     (m_ready),
    .q     (rdy_s)
  );

  assign {pick_found, pick_idx} = rr_pick(req_valid, ptr);
  assign grant = (state == IDLE) && pick_found && rdy_s;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (grant) next_state = LAUNCH;
      LAUNCH:    if (!rdy_s) next_state = WAIT_DONE;
                 else if (cnt == START_LAST) next_state = RESP;
      WAIT_DONE: if (rdy_s || cnt == DONE_LAST) next_state = RESP;
      default:   next_state = IDLE;
    endcase
  end

  // Counter is reused per phase and saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      m_addr    <= '0;
      m_rw      <= 1'b0;
      m_data_in <= '0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (grant) begin
            m_addr    <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            m_data_in <= req_wdata[pick_idx*DATA_W +: DATA_W];
            m_rw      <= req_rw[pick_idx];
            owner     <= pick_idx;
            ptr       <= (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            err       <= 1'b0;
          end
        end
        LAUNCH: begin
          if (!rdy_s) begin
            cnt <= '0;
          end else begin
            if (cnt == START_LAST) err <= 1'b1;
            if (cnt != '1) cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (rdy_s) begin
            rsp_rdata <= m_data_out;
            err       <= 1'b0;
          end else begin
            if (cnt == DONE_LAST) err <= 1'b1;
            if (cnt != '1) cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // The accept pulse lands on the first LAUNCH cycle, the only one with cnt still zero.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    m_enable  = (state == LAUNCH);
    busy      = (state != IDLE);
    rsp_err   = (state == RESP) && err;
    if (state == LAUNCH && cnt == '0) req_ready[owner] = 1'b1;
    if (state == RESP) rsp_valid[owner] = 1'b1;
  end
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: a master model, a transaction-level
// reference checked every cycle, and literal expectations per scenario.
module tb_i2c_txn_arbiter;
  localparam int NREQ        = 4;
  localparam int SYNC_STAGES = 2;
  localparam int START_TO    = 64;
  localparam int DONE_TO     = 4096;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [7*NREQ-1:0] req_addr = '0;
  logic [NREQ-1:0]   req_rw = '0;
  logic [8*NREQ-1:0] req_wdata = '0;
  logic [NREQ-1:0]   req_ready, rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_err, busy;
  logic [6:0]        m_addr;
  logic [7:0]        m_data_in;
  logic              m_rw, m_enable;
  logic              m_ready = 1'b1;
  logic [7:0]        m_data_out = 8'hA5;

  int n_checks = 0;
  int n_pass   = 0;
  int master_mode = 0;
  int en_cnt = 0;
  int low_cnt = 0;
  int enable_cycles = 0;
  int grant_q[$];
  int rsp_owner_q[$];
  logic rsp_err_q[$];
  logic [7:0] rsp_data_q[$];

  i2c_txn_arbiter #(
    .NREQ(NREQ), .SYNC_STAGES(SYNC_STAGES), .START_TO(START_TO), .DONE_TO(DONE_TO)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_rw(req_rw), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_rw(m_rw), .m_enable(m_enable),
    .m_ready(m_ready), .m_data_out(m_data_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Master model: mode 0 normal (ready drops 3 clk after enable, returns 40 later),
  // mode 1 never drops ready, mode 2 drops but never raises it again.
  always @(posedge clk) begin
    if (master_mode != 1) begin
      if (m_ready) begin
        if (m_enable) begin
          if (en_cnt == 2) begin
            m_ready <= 1'b0;
            low_cnt <= 0;
            en_cnt  <= 0;
          end else begin
            en_cnt <= en_cnt + 1;
          end
        end else begin
          en_cnt <= 0;
        end
      end else if (master_mode == 0) begin
        if (low_cnt == 39) m_ready <= 1'b1;
        low_cnt <= low_cnt + 1;
      end
    end
  end

  // Event log of grants, responses and enable cycles for the directed checks.
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) grant_q.push_back(i);
      if (rsp_valid[i]) begin
        rsp_owner_q.push_back(i);
        rsp_err_q.push_back(rsp_err);
        rsp_data_q.push_back(rsp_rdata);
      end
    end
    if (m_enable) enable_cycles++;
  end

  // Transaction-level reference: one in-flight transaction with phase flags and elapsed time.
  logic                   mdl_active = 1'b0, mdl_just = 1'b0, mdl_fallen = 1'b0;
  logic                   mdl_done = 1'b0, mdl_err = 1'b0, mdl_rw = 1'b0;
  int                     mdl_owner = 0, mdl_ptr = 0, mdl_elapsed = 0;
  logic [6:0]             mdl_addr = '0;
  logic [7:0]             mdl_wdata = '0, mdl_rdata = '0;
  logic [SYNC_STAGES-1:0] mdl_sync = '1;

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready, exp_valid;
    logic rdy;
    int win;
    rdy = mdl_sync[SYNC_STAGES-1];
    exp_ready = '0;
    exp_valid = '0;
    if (mdl_active && mdl_just) exp_ready[mdl_owner] = 1'b1;
    if (mdl_done) exp_valid[mdl_owner] = 1'b1;
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    checkOutput("busy", 32'(busy), 32'(mdl_active));
    checkOutput("m_enable", 32'(m_enable), 32'(mdl_active && !mdl_fallen && !mdl_done));
    checkOutput("m_addr", 32'(m_addr), 32'(mdl_addr));
    checkOutput("m_rw", 32'(m_rw), 32'(mdl_rw));
    checkOutput("m_data_in", 32'(m_data_in), 32'(mdl_wdata));
    checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(mdl_rdata));
    if (exp_valid != '0) checkOutput("rsp_err", 32'(rsp_err), 32'(mdl_err));

    if (reset) begin
      mdl_active = 0; mdl_just = 0; mdl_fallen = 0; mdl_done = 0; mdl_err = 0;
      mdl_owner = 0; mdl_ptr = 0; mdl_elapsed = 0;
      mdl_addr = '0; mdl_rw = 0; mdl_wdata = '0; mdl_rdata = '0;
      mdl_sync = '1;
    end else begin
      mdl_just = 0;
      if (mdl_done) begin
        mdl_active = 0;
        mdl_done = 0;
      end else if (!mdl_active) begin
        win = -1;
        if (rdy) begin
          for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(mdl_ptr + k) % NREQ]) win = (mdl_ptr + k) % NREQ;
          end
        end
        if (win >= 0) begin
          mdl_active = 1; mdl_just = 1; mdl_fallen = 0; mdl_elapsed = 0; mdl_err = 0;
          mdl_owner = win;
          mdl_ptr   = (win + 1) % NREQ;
          mdl_addr  = req_addr[win*7 +: 7];
          mdl_rw    = req_rw[win];
          mdl_wdata = req_wdata[win*8 +: 8];
        end
      end else if (!mdl_fallen) begin
        if (!rdy) begin
          mdl_fallen = 1;
          mdl_elapsed = 0;
        end else begin
          mdl_elapsed++;
          if (mdl_elapsed >= START_TO) begin mdl_done = 1; mdl_err = 1; end
        end
      end else begin
        if (rdy) begin
          mdl_rdata = m_data_out; mdl_err = 0; mdl_done = 1;
        end else begin
          mdl_elapsed++;
          if (mdl_elapsed >= DONE_TO) begin mdl_done = 1; mdl_err = 1; end
        end
      end
      mdl_sync = {mdl_sync[SYNC_STAGES-2:0], m_ready};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [6:0] a,
                               input logic r, input logic [7:0] w);
    req_valid[idx]        = v;
    req_addr[idx*7 +: 7]  = a;
    req_rw[idx]           = r;
    req_wdata[idx*8 +: 8] = w;
  endtask

  task automatic waitGrants(input int total, input int budget, input string name);
    int c = 0;
    while (grant_q.size() < total && c < budget) begin tick(1); c++; end
    checkOutput(name, 32'(grant_q.size() >= total), 32'd1);
  endtask

  task automatic waitRsps(input int total, input int budget, input string name);
    int c = 0;
    while (rsp_owner_q.size() < total && c < budget) begin tick(1); c++; end
    checkOutput(name, 32'(rsp_owner_q.size() >= total), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int gb, rb, eb, c;
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    tick(3);
    reset = 1'b0;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
    checkOutput("reset m_addr", 32'(m_addr), 32'd0);

    $display("[TB] single write");
    gb = grant_q.size(); rb = rsp_owner_q.size();
    applyStimulus(0, 1'b1, 7'h50, 1'b0, 8'h3C);
    waitGrants(gb + 1, 20, "wr grant seen");
    applyStimulus(0, 1'b0, 7'h50, 1'b0, 8'h3C);
    checkOutput("wr grant idx", 32'(grant_q[gb]), 32'd0);
    checkOutput("wr m_addr", 32'(m_addr), 32'h50);
    checkOutput("wr m_data_in", 32'(m_data_in), 32'h3C);
    checkOutput("wr m_rw", 32'(m_rw), 32'd0);
    waitRsps(rb + 1, 200, "wr rsp seen");
    checkOutput("wr rsp owner", 32'(rsp_owner_q[rb]), 32'd0);
    checkOutput("wr rsp err", 32'(rsp_err_q[rb]), 32'd0);

    $display("[TB] single read");
    gb = grant_q.size(); rb = rsp_owner_q.size();
    applyStimulus(2, 1'b1, 7'h68, 1'b1, 8'h00);
    waitGrants(gb + 1, 20, "rd grant seen");
    applyStimulus(2, 1'b0, 7'h68, 1'b1, 8'h00);
    waitRsps(rb + 1, 200, "rd rsp seen");
    checkOutput("rd rsp owner", 32'(rsp_owner_q[rb]), 32'd2);
    checkOutput("rd rsp rdata", 32'(rsp_data_q[rb]), 32'hA5);
    checkOutput("rd rsp err", 32'(rsp_err_q[rb]), 32'd0);

    $display("[TB] contention");
    tick(2); reset = 1'b1; tick(1); reset = 1'b0;
    gb = grant_q.size(); rb = rsp_owner_q.size();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b1, 7'(8'h20 + i), i[0], 8'(16 * i));
    waitGrants(gb + 5, 1000, "rr five grants");
    req_valid = '0;
    waitRsps(rb + 5, 300, "rr five rsps");
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("rr grant %0d", k), 32'(grant_q[gb + k]), 32'(rr_exp[k]));
      checkOutput($sformatf("rr rsp %0d", k), 32'(rsp_owner_q[rb + k]), 32'(rr_exp[k]));
    end

    $display("[TB] start timeout");
    master_mode = 1;
    gb = grant_q.size(); rb = rsp_owner_q.size(); eb = enable_cycles;
    applyStimulus(3, 1'b1, 7'h11, 1'b0, 8'h77);
    waitGrants(gb + 1, 20, "sto grant seen");
    applyStimulus(3, 1'b0, 7'h11, 1'b0, 8'h77);
    waitRsps(rb + 1, 200, "sto rsp seen");
    checkOutput("sto enable cycles", 32'(enable_cycles - eb), 32'(START_TO));
    checkOutput("sto rsp err", 32'(rsp_err_q[rb]), 32'd1);
    tick(1);
    checkOutput("sto idle busy", 32'(busy), 32'd0);
    master_mode = 0;

    $display("[TB] done timeout");
    master_mode = 2;
    gb = grant_q.size(); rb = rsp_owner_q.size();
    applyStimulus(1, 1'b1, 7'h22, 1'b1, 8'h00);
    waitGrants(gb + 1, 20, "dto grant seen");
    applyStimulus(1, 1'b0, 7'h22, 1'b1, 8'h00);
    waitRsps(rb + 1, DONE_TO + 200, "dto rsp seen");
    checkOutput("dto rsp err", 32'(rsp_err_q[rb]), 32'd1);
    applyStimulus(0, 1'b1, 7'h33, 1'b0, 8'h44);
    tick(20);
    checkOutput("dto no grant", 32'(grant_q.size()), 32'(gb + 1));
    master_mode = 0;
    waitGrants(gb + 2, 200, "dto regrant seen");
    applyStimulus(0, 1'b0, 7'h33, 1'b0, 8'h44);
    checkOutput("dto regrant idx", 32'(grant_q[gb + 1]), 32'd0);
    waitRsps(rb + 2, 200, "dto second rsp");

    $display("[TB] reset in WAIT_DONE");
    gb = grant_q.size(); rb = rsp_owner_q.size();
    applyStimulus(2, 1'b1, 7'h45, 1'b0, 8'h99);
    waitGrants(gb + 1, 20, "rst grant seen");
    applyStimulus(2, 1'b0, 7'h45, 1'b0, 8'h99);
    tick(15);
    reset = 1'b1; tick(1); reset = 1'b0;
    tick(10);
    checkOutput("rst no rsp", 32'(rsp_owner_q.size()), 32'(rb));
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst m_enable", 32'(m_enable), 32'd0);
    checkOutput("rst m_addr", 32'(m_addr), 32'd0);
    c = 0;
    while (!m_ready && c < 100) begin tick(1); c++; end
    checkOutput("rst master ready", 32'(m_ready), 32'd1);
    tick(SYNC_STAGES + 1);
    applyStimulus(1, 1'b1, 7'h5A, 1'b1, 8'h00);
    waitGrants(gb + 2, 20, "post rst grant");
    applyStimulus(1, 1'b0, 7'h5A, 1'b1, 8'h00);
    checkOutput("post rst idx", 32'(grant_q[gb + 1]), 32'd1);
    waitRsps(rb + 1, 200, "post rst rsp");
    checkOutput("post rst owner", 32'(rsp_owner_q[rb]), 32'd1);
    checkOutput("post rst err", 32'(rsp_err_q[rb]), 32'd0);
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
